hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before halting; legal range 1..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 IF_ID_rs1, IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ID_EX_rd  input  5  destination register of the instruction in EX.
REQ-006 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-007 branch_taken  input  1  taken branch or jump resolved this cycle.
REQ-008 dmem_req, dmem_ready  input  1 each  MEM-stage data-memory access request and completion.
REQ-009 pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  pipeline-register load enables (1 = advance).
REQ-010 if_id_flush, id_ex_flush  output  1 each  force the next capture of that register to a bubble with all control bits 0.
REQ-011 mem_wb_bubble  output  1  MEM_WB captures MemtoReg=0, RegWrite=0, rd=0 this cycle.
REQ-012 state  output  2  RUN=0, MEM_WAIT=1, HALT=2.
REQ-013 halted  output  1  high iff state==HALT.
REQ-014 stall_cycles  output  32  count of cycles with pc_write=0, saturating.
REQ-015 flush_count  output  16  count of branch flushes, saturating.

Function
REQ-016 state, wait_cnt (16-bit internal), stall_cycles and flush_count are registered; all enable/flush outputs are combinational from state and current inputs.
REQ-017 Freeze condition F = dmem_req & ~dmem_ready.
REQ-018 Load-use condition LU = ID_EX_MemRead & (ID_EX_rd != 0) & (ID_EX_rd == IF_ID_rs1 | ID_EX_rd == IF_ID_rs2).
REQ-019 RUN, F=1: all four write enables 0, mem_wb_bubble=1, flushes 0; next state MEM_WAIT, wait_cnt <= 1.
REQ-020 RUN, F=0, branch_taken=1: all write enables 1, if_id_flush=1, id_ex_flush=1; flush_count increments; LU is ignored.
REQ-021 RUN, F=0, branch_taken=0, LU=1: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1; exactly one bubble inserted per hazard cycle.
REQ-022 RUN, no condition: all write enables 1, all flushes and mem_wb_bubble 0.
REQ-023 Priority within a cycle: F over branch_taken over LU.
REQ-024 MEM_WAIT, dmem_ready=0, wait_cnt < TIMEOUT: outputs as REQ-019; wait_cnt increments; stay.
REQ-025 MEM_WAIT, dmem_ready=0, wait_cnt == TIMEOUT: outputs as REQ-019; next state HALT.
REQ-026 MEM_WAIT, dmem_ready=1: outputs decoded as RUN with F=0 (REQ-020..022, branch and LU honoured); next state RUN; wait_cnt <= 0.
REQ-027 HALT: all write enables 0, mem_wb_bubble=1, flushes 0; state held until reset; all inputs ignored.
REQ-028 stall_cycles increments by 1 every cycle pc_write=0 (includes HALT); holds at 0xFFFFFFFF.
REQ-029 flush_count holds at 0xFFFF.
REQ-030 dmem_ready with dmem_req=0 in RUN has no effect.

Reset
REQ-031 reset=1 at a rising edge: state<=RUN, wait_cnt<=0, stall_cycles<=0, flush_count<=0, overriding every other transition, including from MEM_WAIT or HALT.
REQ-032 While reset is high, outputs decode as RUN with F=0 from current inputs; counters do not increment.

Verification
REQ-033 ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5, one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1; same with rd=0 -> no stall.
REQ-034 dmem_req=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with mem_wb_bubble=1, state MEM_WAIT cycles 2-3, release in cycle 4, stall_cycles=3.
REQ-035 branch_taken=1 and LU=1 in the same cycle -> flushes 1, pc_write=1, flush_count+1, no stall.
REQ-036 TIMEOUT=4, dmem_req=1, dmem_ready=0 held -> HALT entered after the 5th freeze cycle; halted=1; dmem_ready=1 afterwards ignored.
REQ-037 reset asserted in MEM_WAIT and in HALT -> next cycle state=0, counters 0, pc_write=1.
REQ-038 stall_cycles preloaded via force to 0xFFFFFFFE, 3 stall cycles -> reads 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory freeze
// with a watchdog that halts the pipeline if memory never answers.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_MemRead,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      st;
    logic [15:0] wait_cnt;
    logic        freeze_in;
    logic        lu;
    logic        freeze;
    logic        br_flush;

    assign freeze_in = dmem_req & ~dmem_ready;
    assign lu = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2));

    // During reset the decode behaves as RUN with no memory freeze.
    always_comb begin
        freeze = 1'b0;
        if (!reset) begin
            case (st)
                RUN:      freeze = freeze_in;
                MEM_WAIT: freeze = ~dmem_ready;
                HALT:     freeze = 1'b1;
                default:  freeze = 1'b0;
            endcase
        end
    end

    // Priority: freeze, then branch flush, then load-use bubble.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        br_flush      = 1'b0;
        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= RUN;
            wait_cnt     <= 16'd0;
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!pc_write && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (br_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
            case (st)
                RUN: begin
                    if (freeze_in) begin
                        st       <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        st       <= RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt >= TO) begin
                        st <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HALT:    st <= HALT;
                default: st <= RUN;
            endcase
        end
    end

    assign state  = st;
    assign halted = (st == HALT);

endmodule
